// File: rtl/pingpong_buffer_if.sv
// Producer/consumer bundle for the ping-pong buffer.
// master = router/PE side, slave = buffer.
interface pingpong_buffer_if #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 6
);
  logic                 writeEn;
  logic [AddrWidth-1:0] writeAddr;
  logic [DataWidth-1:0] dataIn;
  logic                 writeDone;
  logic                 writeReady;
  logic                 readEn;
  logic [AddrWidth-1:0] readAddr;
  logic                 readDone;
  logic                 readReady;
  logic [DataWidth-1:0] dataOut;
  logic                 dataOutValid;
  logic [1:0]           fullCount;
  logic                 errDropped;

  modport master (
    output writeEn, writeAddr, dataIn, writeDone,
    output readEn, readAddr, readDone,
    input  writeReady, readReady, dataOut,
    input  dataOutValid, fullCount, errDropped
  );

  modport slave (
    input  writeEn, writeAddr, dataIn, writeDone,
    input  readEn, readAddr, readDone,
    output writeReady, readReady, dataOut,
    output dataOutValid, fullCount, errDropped
  );
endinterface

// File: rtl/pingpong_buffer.sv
// Two-bank ping-pong buffer with commit/release bank handoff.
// Optional PINGPONG_ERR_EN: sticky errDropped flag plus drop log.
module pingpong_buffer #(
  parameter int Depth     = 64,
  parameter int DataWidth = 8,
  parameter int AddrWidth = $clog2(Depth)
) (
  input logic            clk,
  input logic            rst,
  pingpong_buffer_if.slave bus
);
  localparam logic [AddrWidth:0] DepthL =
    (AddrWidth+1)'(Depth);

  logic [DataWidth-1:0] r_mem0 [Depth];
  logic [DataWidth-1:0] r_mem1 [Depth];

  logic [1:0]           r_bankFull;
  logic [1:0]           w_bankFullNxt;
  logic                 r_wrSel;
  logic                 r_rdSel;
  logic [DataWidth-1:0] r_dataOut;
  logic                 r_dataOutValid;

  logic                 w_writeReady;
  logic                 w_readReady;
  logic                 w_wrInRange;
  logic                 w_rdInRange;
  logic                 w_wrFire;
  logic                 w_rdFire;
  logic                 w_commit;
  logic                 w_release;
  logic [DataWidth-1:0] w_rdData;

  assign w_writeReady = !r_bankFull[r_wrSel];
  assign w_readReady  = r_bankFull[r_rdSel];

  assign w_wrInRange = {1'b0, bus.writeAddr} < DepthL;
  assign w_rdInRange = {1'b0, bus.readAddr} < DepthL;

  assign w_wrFire  = bus.writeEn && w_writeReady
                  && w_wrInRange;
  assign w_rdFire  = bus.readEn && w_readReady;
  assign w_commit  = bus.writeDone && w_writeReady;
  assign w_release = bus.readDone && w_readReady;

  // Commit targets an empty bank, release a full one,
  // so both may apply in the same cycle.
  always_comb begin
    w_bankFullNxt = r_bankFull;
    if (w_commit)
      w_bankFullNxt[r_wrSel] = 1'b1;
    if (w_release)
      w_bankFullNxt[r_rdSel] = 1'b0;
  end

  always_comb begin
    w_rdData = '0;
    if (w_rdInRange)
      w_rdData = r_rdSel ? r_mem1[bus.readAddr]
                         : r_mem0[bus.readAddr];
  end

  always_ff @(posedge clk) begin
    if (w_wrFire) begin
      if (r_wrSel)
        r_mem1[bus.writeAddr] <= bus.dataIn;
      else
        r_mem0[bus.writeAddr] <= bus.dataIn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bankFull <= 2'b00;
      r_wrSel    <= 1'b0;
      r_rdSel    <= 1'b0;
    end else begin
      r_bankFull <= w_bankFullNxt;
      if (w_commit)
        r_wrSel <= !r_wrSel;
      if (w_release)
        r_rdSel <= !r_rdSel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dataOut      <= '0;
      r_dataOutValid <= 1'b0;
    end else begin
      r_dataOutValid <= w_rdFire;
      if (w_rdFire)
        r_dataOut <= w_rdData;
    end
  end

  assign bus.writeReady   = w_writeReady;
  assign bus.readReady    = w_readReady;
  assign bus.dataOut      = r_dataOut;
  assign bus.dataOutValid = r_dataOutValid;
  assign bus.fullCount    = {1'b0, r_bankFull[0]}
                          + {1'b0, r_bankFull[1]};

`ifdef PINGPONG_ERR_EN
  logic r_errDropped;
  logic w_wrDrop;
  logic w_rdDrop;

  assign w_wrDrop = (bus.writeEn || bus.writeDone)
                 && !w_writeReady;
  assign w_rdDrop = (bus.readEn || bus.readDone)
                 && !w_readReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_errDropped <= 1'b0;
    else if (w_wrDrop || w_rdDrop)
      r_errDropped <= 1'b1;
  end

  always @(posedge clk) begin
    if (!rst && w_wrDrop)
      $display("[pingpong_buffer] dropped %s addr=%0d t=%0t",
        bus.writeEn ? "write" : "writeDone",
        bus.writeAddr, $time);
    if (!rst && w_rdDrop)
      $display("[pingpong_buffer] dropped %s addr=%0d t=%0t",
        bus.readEn ? "read" : "readDone",
        bus.readAddr, $time);
  end

  assign bus.errDropped = r_errDropped;
`else
  assign bus.errDropped = 1'b0;
`endif
endmodule

// File: tb/tb_pingpong_buffer.sv
// Scoreboard bench for pingpong_buffer (Depth=4, DataWidth=8).
// Expected read data is queued when readEn is driven.
module tb_pingpong_buffer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] sb_q[$];

`ifdef PINGPONG_ERR_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  pingpong_buffer_if #(.DataWidth(8), .AddrWidth(2)) bus ();

  pingpong_buffer #(
    .Depth(4), .DataWidth(8), .AddrWidth(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.writeEn   = 1'b0;
    bus.writeAddr = 2'd0;
    bus.dataIn    = 8'd0;
    bus.writeDone = 1'b0;
    bus.readEn    = 1'b0;
    bus.readAddr  = 2'd0;
    bus.readDone  = 1'b0;
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (bus.dataOutValid === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got dataOut=%h, required no valid",
                 bus.dataOut);
      end else begin
        e = sb_q.pop_front();
        if (bus.dataOut !== e) begin
          n_fail++;
          $display("FAIL read_data: got %h, required %h", bus.dataOut, e);
        end
      end
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] wa,
                       input logic [7:0] d, input logic wd,
                       input logic re, input logic [1:0] ra,
                       input logic rd);
    bus.writeEn = we; bus.writeAddr = wa; bus.dataIn = d;
    bus.writeDone = wd;
    bus.readEn = re; bus.readAddr = ra; bus.readDone = rd;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1;
    n_tests++;
    if (bus.writeReady !== 1'b1 || bus.readReady !== 1'b0 ||
        bus.fullCount !== 2'd0 || bus.dataOut !== 8'd0 ||
        bus.dataOutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got wr=%b rr=%b fc=%0d do=%h v=%b, required 1 0 0 00 0",
               bus.writeReady, bus.readReady, bus.fullCount,
               bus.dataOut, bus.dataOutValid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_empty_read();
    drive(0, 0, 0, 0, 1, 2'd0, 0);
    n_tests++;
    if (bus.dataOutValid !== 1'b0 || bus.dataOut !== 8'd0 ||
        bus.readReady !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_read: got v=%b do=%h rr=%b, required 0 00 0",
               bus.dataOutValid, bus.dataOut, bus.readReady);
    end
    n_tests++;
    if (bus.errDropped !== ErrExp) begin
      n_fail++;
      $display("FAIL empty_read_err: got %b, required %b",
               bus.errDropped, ErrExp);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.fullCount !== 2'd0) begin
        n_fail++;
        $display("FAIL fd_fc0: got %0d, required 0", bus.fullCount);
      end
      drive(1, 2'(i), 8'(8'h11 * (i + 1)), 0, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    n_tests++;
    if (bus.fullCount !== 2'd1 || bus.readReady !== 1'b1) begin
      n_fail++;
      $display("FAIL fd_commit: got fc=%0d rr=%b, required 1 1",
               bus.fullCount, bus.readReady);
    end
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(8'(8'h11 * (i + 1)));
      drive(0, 0, 0, 0, 1, 2'(i), 0);
      n_tests++;
      if (bus.dataOutValid !== 1'b1) begin
        n_fail++;
        $display("FAIL fd_valid%0d: got %b, required 1",
                 i, bus.dataOutValid);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus.dataOutValid !== 1'b0 || bus.fullCount !== 2'd0) begin
      n_fail++;
      $display("FAIL fd_release: got v=%b fc=%0d, required 0 0",
               bus.dataOutValid, bus.fullCount);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    drive(1, 2'd0, 8'h99, 1, 0, 0, 0);
    sb_q.push_back(8'h99);
    drive(0, 0, 0, 0, 1, 2'd0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.writeReady !== 1'b1 || bus.readReady !== 1'b0 ||
        bus.fullCount !== 2'd0 || bus.dataOut !== 8'd0 ||
        bus.dataOutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got wr=%b rr=%b fc=%0d do=%h v=%b, required 1 0 0 00 0",
               bus.writeReady, bus.readReady, bus.fullCount,
               bus.dataOut, bus.dataOutValid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pingpong();
    do_reset();
    for (int i = 0; i < 4; i++)
      drive(1, 2'(i), 8'(8'hA0 + i), 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(8'(8'hA0 + i));
      drive(1, 2'(i), 8'(8'hB0 + i), 0, 1, 2'(i), 0);
      n_tests++;
      if (bus.fullCount !== 2'd1) begin
        n_fail++;
        $display("FAIL pp_fc%0d: got %0d, required 1", i, bus.fullCount);
      end
    end
    drive(0, 0, 0, 1, 0, 0, 1);
    n_tests++;
    if (bus.fullCount !== 2'd1 || bus.readReady !== 1'b1 ||
        bus.writeReady !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_swap: got fc=%0d rr=%b wr=%b, required 1 1 1",
               bus.fullCount, bus.readReady, bus.writeReady);
    end
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(8'(8'hB0 + i));
      drive(0, 0, 0, 0, 1, 2'(i), i == 3);
    end
    n_tests++;
    if (bus.fullCount !== 2'd0) begin
      n_fail++;
      $display("FAIL pp_end_fc: got %0d, required 0", bus.fullCount);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 2'd0, 8'h77, 1, 0, 0, 0);
    drive(1, 2'd0, 8'h88, 1, 0, 0, 0);
    n_tests++;
    if (bus.fullCount !== 2'd2 || bus.writeReady !== 1'b0 ||
        bus.readReady !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: got fc=%0d wr=%b rr=%b, required 2 0 1",
               bus.fullCount, bus.writeReady, bus.readReady);
    end
    drive(1, 2'd0, 8'hFF, 0, 0, 0, 0);
    n_tests++;
    if (bus.errDropped !== ErrExp || bus.fullCount !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_drop: got err=%b fc=%0d, required %b 2",
               bus.errDropped, bus.fullCount, ErrExp);
    end
    sb_q.push_back(8'h77);
    bus.readEn = 1'b1; bus.readAddr = 2'd0; bus.readDone = 1'b1;
    #1;
    n_tests++;
    if (bus.writeReady !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release_cycle: got wr=%b, required 0",
               bus.writeReady);
    end
    tick();
    idle();
    n_tests++;
    if (bus.writeReady !== 1'b1 || bus.fullCount !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_after_release: got wr=%b fc=%0d, required 1 1",
               bus.writeReady, bus.fullCount);
    end
    sb_q.push_back(8'h88);
    drive(0, 0, 0, 0, 1, 2'd0, 1);
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(1, 2'd3, 8'h5A, 1, 0, 0, 0);
    n_tests++;
    if (bus.readReady !== 1'b1) begin
      n_fail++;
      $display("FAIL sc_commit: got rr=%b, required 1", bus.readReady);
    end
    sb_q.push_back(8'h5A);
    drive(0, 0, 0, 0, 1, 2'd3, 1);
    n_tests++;
    if (bus.dataOutValid !== 1'b1 || bus.readReady !== 1'b0 ||
        bus.fullCount !== 2'd0) begin
      n_fail++;
      $display("FAIL sc_release: got v=%b rr=%b fc=%0d, required 1 0 0",
               bus.dataOutValid, bus.readReady, bus.fullCount);
    end
    drive(1, 2'd0, 8'hC3, 1, 0, 0, 0);
    n_tests++;
    if (bus.readReady !== 1'b1) begin
      n_fail++;
      $display("FAIL sc_rdsel: got rr=%b, required 1", bus.readReady);
    end
    sb_q.push_back(8'hC3);
    drive(0, 0, 0, 0, 1, 2'd0, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    test_reset();
    test_empty_read();
    test_fill_drain();
    test_reset_midrun();
    test_pingpong();
    test_backpressure();
    test_same_cycle();
    tick();
    tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending reads, required 0",
               sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
